// File: rtl/gaussian_line_reader.sv
// Streaming cache-line reader for CCI-P channel 0: credit-limited in-order read issue feeding a
// show-ahead response FIFO. Define GAUSSIAN_RD_PERF_CNT_EN to add saturating perf counters.
module gaussian_line_reader #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int LINE_ADDR_W     = 42,
  parameter int LEN_W           = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LINE_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]       num_lines,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   c0_alm_full,
  output logic                   c0_req_valid,
  output logic [LINE_ADDR_W-1:0] c0_req_addr,
  output logic [15:0]            c0_req_mdata,
  input  logic                   c0_rsp_valid,
  input  logic [511:0]           c0_rsp_data,
  output logic                   out_valid,
  output logic [511:0]           out_data,
  output logic                   out_last,
  input  logic                   out_ready
`ifdef GAUSSIAN_RD_PERF_CNT_EN
  ,
  output logic [31:0]            perf_active_cycles,
  output logic [31:0]            perf_almfull_stalls
`endif
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  logic [LINE_ADDR_W-1:0] base;
  logic [LEN_W-1:0]       len;
  logic [LEN_W-1:0]       issued;
  logic [LEN_W-1:0]       received;
  logic [LEN_W-1:0]       deq_cnt;
  logic                   alm_q;

  logic [511:0]           mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W-1:0]       fifo_count_next;

  logic                   active;
  logic [LEN_W:0]         in_use;
  logic                   has_credit;
  logic                   issue;
  logic                   rsp_accept;
  logic                   rsp_stray;
  logic                   deq;

  assign active     = (state == RUN) || (state == DRAIN);
  // Lines in flight plus lines parked in the FIFO can never exceed the FIFO depth.
  assign in_use     = {1'b0, issued - received} + (LEN_W+1)'(fifo_count);
  assign has_credit = in_use < (LEN_W+1)'(MAX_OUTSTANDING);
  assign issue      = (state == RUN) && !alm_q && has_credit && (issued < len);
  assign rsp_accept = c0_rsp_valid && active && (issued != received);
  assign rsp_stray  = c0_rsp_valid && active && (issued == received);
  assign deq        = out_valid && out_ready;

  assign fifo_count_next = fifo_count + CNT_W'(rsp_accept) - CNT_W'(deq);

  assign busy      = active;
  assign done      = (state == DONE);
  assign out_valid = (fifo_count != '0);
  assign out_data  = mem[rd_ptr];
  assign out_last  = out_valid && (deq_cnt == len - LEN_W'(1));

  // NOTE: sequential state uses <= so every register in the block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      base         <= '0;
      len          <= '0;
      issued       <= '0;
      received     <= '0;
      deq_cnt      <= '0;
      alm_q        <= 1'b0;
      err          <= 1'b0;
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
    end else begin
      alm_q        <= c0_alm_full;
      c0_req_valid <= issue;
      fifo_count   <= fifo_count_next;
      if (issue) begin
        c0_req_addr  <= base + LINE_ADDR_W'(issued);
        c0_req_mdata <= issued[15:0];
        issued       <= issued + LEN_W'(1);
      end
      if (rsp_accept) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        received <= received + LEN_W'(1);
      end
      if (rsp_stray)
        err <= 1'b1;
      if (deq) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        deq_cnt <= deq_cnt + LEN_W'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            base     <= base_addr;
            len      <= num_lines;
            issued   <= '0;
            received <= '0;
            deq_cnt  <= '0;
            err      <= 1'b0;
            state    <= (num_lines == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (issue && (issued + LEN_W'(1) == len))
            state <= DRAIN;
        end
        DRAIN: begin
          // Leave as the final beat is accepted so done appears the very next cycle.
          if ((received == len) && (fifo_count_next == '0))
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the data array carries no reset; the FIFO pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (rsp_accept)
      mem[wr_ptr] <= c0_rsp_data;
  end

`ifdef GAUSSIAN_RD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_active_cycles  <= '0;
      perf_almfull_stalls <= '0;
    end else if (start && ((state == IDLE) || (state == DONE))) begin
      perf_active_cycles  <= '0;
      perf_almfull_stalls <= '0;
    end else begin
      if (active && (perf_active_cycles != '1))
        perf_active_cycles <= perf_active_cycles + 32'd1;
      if ((state == RUN) && (issued < len) && c0_alm_full && (perf_almfull_stalls != '1))
        perf_almfull_stalls <= perf_almfull_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gaussian_line_reader.sv
// Self-checking bench for gaussian_line_reader: an in-order memory responder plus a per-cycle
// scoreboard that derives every request address and beat payload from the line index.
module tb_gaussian_line_reader;

  localparam int MAX = 4;
  localparam int AW  = 42;
  localparam int LW  = 32;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [LW-1:0]  num_lines;
  logic           busy, done, err;
  logic           c0_alm_full = 1'b0;
  logic           c0_req_valid;
  logic [AW-1:0]  c0_req_addr;
  logic [15:0]    c0_req_mdata;
  logic           c0_rsp_valid = 1'b0;
  logic [511:0]   c0_rsp_data = '0;
  logic           out_valid;
  logic [511:0]   out_data;
  logic           out_last;
  logic           out_ready = 1'b1;
`ifdef GAUSSIAN_RD_PERF_CNT_EN
  logic [31:0]    perf_active_cycles, perf_almfull_stalls;
`endif

  always #5 clk = ~clk;

  gaussian_line_reader #(.MAX_OUTSTANDING(MAX), .LINE_ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err), .c0_alm_full(c0_alm_full),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
`ifdef GAUSSIAN_RD_PERF_CNT_EN
    , .perf_active_cycles(perf_active_cycles), .perf_almfull_stalls(perf_almfull_stalls)
`endif
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Payload the memory returns for a line; depends on every address bit.
  function automatic logic [511:0] line_data(input logic [AW-1:0] a);
    logic [511:0] d;
    for (int j = 0; j < 16; j++)
      d[j*32 +: 32] = (a[31:0] * 32'h9E37_79B1) ^ {22'h0, a[41:32]} ^ (32'(j) << 20);
    return d;
  endfunction

  // Reference job state: what the stream must look like, by line index.
  logic [AW-1:0] job_base = '0;
  int unsigned   job_n = 0;
  int unsigned   req_idx = 0;
  int unsigned   beat_idx = 0;
  logic          job_active = 1'b0;
  logic [AW-1:0] last_req_addr = '0;

  // Input drivers: modes chosen by the main sequence, applied on each falling edge.
  int ready_mode = 1;
  int alm_mode   = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    case (alm_mode)
      0:       c0_alm_full = 1'b0;
      1:       c0_alm_full = 1'b1;
      default: c0_alm_full = ($urandom_range(0, 5) == 0);
    endcase
  end

  // Memory responder: in-order, fixed or random latency, plus on-demand stray responses.
  int            resp_delay = 0;
  int            inject_req = 0;
  int            inject_done = 0;
  logic [AW-1:0] pend_addr[$];
  longint        pend_due[$];
  longint        cyc = 0;
  longint        last_due = 0;
  always @(negedge clk) begin
    longint due;
    cyc++;
    if (c0_req_valid) begin
      due = cyc + ((resp_delay == 0) ? longint'($urandom_range(1, 6)) : longint'(resp_delay));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(c0_req_addr);
      pend_due.push_back(due);
    end
    c0_rsp_valid = 1'b0;
    c0_rsp_data  = '0;
    if (inject_done != inject_req) begin
      c0_rsp_valid = 1'b1;
      c0_rsp_data  = {16{32'hDEAD_BEEF}};
      inject_done++;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      c0_rsp_valid = 1'b1;
      c0_rsp_data  = line_data(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
  end

  // Scoreboard: runs every cycle, mid-cycle, while reset is released.
  logic [511:0]  hold_data = '0;
  logic          hold_pend = 1'b0;
  logic          alm_d1 = 1'b0, alm_d2 = 1'b0;
  logic          exp_done = 1'b0;
  logic [AW-1:0] exp_addr;
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (exp_done) begin
        check("done_after_last", {done, busy}, 2'b10);
        exp_done = 1'b0;
      end
      if (alm_d2)
        check("alm_full_honoured", c0_req_valid, 1'b0);
      if (c0_req_valid) begin
        check("req_in_job", job_active && (req_idx < job_n), 1'b1);
        exp_addr = job_base + AW'(req_idx);
        check("req_addr", c0_req_addr, exp_addr);
        check("req_mdata", c0_req_mdata, 16'(req_idx));
        last_req_addr = c0_req_addr;
        req_idx++;
        check("credit_limit", (req_idx - beat_idx) <= MAX, 1'b1);
      end
      if (hold_pend) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, hold_data);
      end
      if (out_valid) begin
        check("out_in_job", job_active && (beat_idx < job_n), 1'b1);
        exp_addr = job_base + AW'(beat_idx);
        check("out_data", out_data, line_data(exp_addr));
        check("out_last", out_last, beat_idx == job_n - 1);
        if (out_ready) begin
          beat_idx++;
          if (beat_idx == job_n) exp_done = 1'b1;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
    end else begin
      hold_pend = 1'b0;
      exp_done  = 1'b0;
    end
    alm_d2 = alm_d1;
    alm_d1 = c0_alm_full;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int unsigned n);
    base_addr  = b;
    num_lines  = LW'(n);
    start      = 1'b1;
    job_base   = b;
    job_n      = n;
    req_idx    = 0;
    beat_idx   = 0;
    job_active = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done; i++) tick();
    check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_reqs(input int unsigned n, input int limit);
    for (int i = 0; i < limit && req_idx < n; i++) tick();
    check("req_wait_timeout", req_idx >= n, 1'b1);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req_valid", c0_req_valid, 1'b0);
    check("rst_req_addr", c0_req_addr, '0);
    check("rst_req_mdata", c0_req_mdata, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
  endtask

  int            n_after;
  logic [AW-1:0] rbase;
  int unsigned   rlen;

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_lines = '0;
    repeat (3) tick();
    check_reset_values();
    reset_n = 1'b1;
    tick();

    // Basic 8-line job with fixed 5-cycle memory latency.
    resp_delay = 5;
    ready_mode = 1;
    start_job(42'h1000, 8);
    check("req_latency_early", c0_req_valid, 1'b0);
    tick();
    check("first_req_valid", c0_req_valid, 1'b1);
    check("first_req_addr", c0_req_addr, 42'h1000);
    check("first_req_mdata", c0_req_mdata, 16'h0);
    wait_done(200);
    check("t1_last_addr", last_req_addr, 42'h1007);
    check("t1_beats", beat_idx, 8);

    // Zero-length job.
    start_job(42'h2000, 0);
    check("zero_len_busy", busy, 1'b0);
    tick();
    check("zero_len_done", done, 1'b1);
    repeat (4) tick();
    check("zero_len_no_req", req_idx, 0);

    // Credit limit with a blocked consumer, then random release.
    resp_delay = 0;
    ready_mode = 0;
    start_job(42'h0ABC_0000, 16);
    repeat (40) tick();
    check("credit_stall_reqs", req_idx, MAX);
    check("credit_stall_head", out_valid, 1'b1);
    ready_mode = 2;
    wait_done(1000);
    check("credit_beats", beat_idx, 16);

    // Almost-full held for 10 cycles mid-run.
    ready_mode = 1;
    resp_delay = 2;
    start_job(42'h0000_5000, 40);
    wait_reqs(5, 100);
    alm_mode = 1;
    tick();
    n_after = 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (c0_req_valid) n_after++;
    end
    check("alm_at_most_one", n_after <= 1, 1'b1);
    alm_mode = 0;
    tick();
    check("alm_resume_f0", c0_req_valid, 1'b0);
    tick();
    check("alm_resume_f1", c0_req_valid, 1'b0);
    tick();
    check("alm_resume_f2", c0_req_valid, 1'b1);
    wait_done(500);
    check("alm_beats", beat_idx, 40);

    // Stray response while draining with nothing outstanding.
    ready_mode = 0;
    resp_delay = 1;
    start_job(42'h3FF_FFFF_FFFE, 3);
    repeat (20) tick();
    check("drain_busy", busy, 1'b1);
    check("drain_head", out_valid, 1'b1);
    check("drain_err_clear", err, 1'b0);
    inject_req++;
    repeat (3) tick();
    check("err_set", err, 1'b1);
    ready_mode = 1;
    wait_done(100);
    check("err_sticky", err, 1'b1);
    check("stray_beats", beat_idx, 3);
    start_job(42'h3FF_FFFF_FFFD, 6);
    check("err_cleared", err, 1'b0);
    wait_done(300);

    // Reset mid-run with three reads in flight.
    ready_mode = 0;
    resp_delay = 20;
    start_job(42'h0077_0000, 10);
    wait_reqs(3, 50);
    reset_n    = 1'b0;
    job_active = 1'b0;
    tick();
    check_reset_values();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 80 && pend_due.size() > 0; i++) tick();
    repeat (3) tick();
    check("late_rsp_drained", pend_due.size(), 0);
    check("late_rsp_err", err, 1'b0);
    check("late_rsp_out_valid", out_valid, 1'b0);
    check("late_rsp_busy", busy, 1'b0);

    // Randomized jobs, including random consumer stalls and almost-full noise.
    resp_delay = 0;
    for (int j = 0; j < 8; j++) begin
      rbase = {$urandom, $urandom};
      if (j == 0) rbase = '1 - AW'(2);
      rlen       = $urandom_range(1, 40);
      ready_mode = (j % 3 == 0) ? 1 : 2;
      alm_mode   = (j % 2 == 0) ? 2 : 0;
      start_job(rbase, rlen);
      wait_done(4000);
      check("rand_beats", beat_idx, rlen);
      check("rand_reqs", req_idx, rlen);
      alm_mode = 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gaussian_line_reader.md
# gaussian_line_reader

Streaming read engine between the application CSRs and the MPF-side CCI-P channel 0. It issues cache-line read requests for a contiguous buffer, limits in-flight reads with a credit scheme, and buffers responses in a FIFO. Data is presented as a valid/ready stream to the Gaussian filter datapath. Responses are consumed in request order because MPF is built with read-response sorting enabled.

## Interface
- MAX_OUTSTANDING, 64: response FIFO depth and in-flight read limit; power of two, 4..512
- LINE_ADDR_W, 42: cache-line address width
- LEN_W, 32: line-count width
- clk  in  1  AFU clock
- reset_n  in  1  synchronous reset, active low
- start  in  1  one-cycle start pulse from CSRs
- base_addr  in  LINE_ADDR_W  first line address; sampled on start
- num_lines  in  LEN_W  number of lines to read; sampled on start
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- err  out  1  sticky unexpected-response flag; cleared by start
- c0_alm_full  in  1  channel 0 almost-full
- c0_req_valid  out  1  read request valid; registered
- c0_req_addr  out  LINE_ADDR_W  request line address
- c0_req_mdata  out  16  request tag: low 16 bits of the line index
- c0_rsp_valid  in  1  read response valid
- c0_rsp_data  in  512  response data
- out_valid  out  1  stream data valid
- out_data  out  512  stream data
- out_last  out  1  marks the final line of the buffer
- out_ready  in  1  downstream accept

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE or DONE with start:
  - latch base_addr and num_lines; clear issued, received, err
  - num_lines==0: go to DONE; otherwise go to RUN
- start in RUN or DRAIN is ignored.
- RUN, issue condition: !c0_alm_full && credits>0 && issued<num_lines.
  - When met, register c0_req_valid=1, c0_req_addr=base+issued, c0_req_mdata=issued[15:0]; issued increments.
  - Move to DRAIN in the cycle issued reaches num_lines.
- credits = MAX_OUTSTANDING − (outstanding + fifo_count), where outstanding = issued − received. A full FIFO therefore can never overflow.
- c0_rsp_valid in RUN or DRAIN:
  - with outstanding>0: write data to the FIFO, received increments
  - with outstanding==0: drop the response, set err
- c0_rsp_valid in IDLE or DONE is dropped and err is not set (covers stale responses after reset).
- DRAIN goes to DONE when received==num_lines and the FIFO is empty (last beat accepted).
- out_last=1 when the FIFO head is the line with index num_lines−1; a dequeue counter tracks this.
- Address arithmetic is modulo 2^LINE_ADDR_W; wrap is silent.
- Reset values: busy, done, err, c0_req_valid, out_valid, out_last = 0; c0_req_addr, c0_req_mdata = 0.

## Timing
- start to first c0_req_valid: 2 cycles (state update, then registered request).
- Sustained issue rate is 1 request/cycle while the issue condition holds.
- c0_alm_full is honoured one cycle late. At most one request issues in the cycle after almost-full rises.
- Response to out_valid: 1 cycle (registered FIFO write, show-ahead read).
- FIFO write and read in the same cycle are both legal, including at full and at empty+1. fifo_count stays unchanged.
- A stream beat transfers on out_valid && out_ready. out_data is held stable while out_valid && !out_ready.
- done rises 1 cycle after the last beat is accepted.

## Configuration
- GAUSSIAN_RD_PERF_CNT_EN defined adds two 32-bit saturating counters, cleared by start:
  - perf_active_cycles: cycles in RUN or DRAIN
  - perf_almfull_stalls: cycles in RUN with issued<num_lines and c0_alm_full=1
  - both exposed as extra output ports of the same names
- Undefined: the ports and counters are absent, and there is no other change in behaviour.

## Test plan
- base=0x1000, num_lines=8, responses 5 cycles after each request, out_ready=1 → 8 requests at addresses 0x1000..0x1007 with mdata 0..7; 8 beats; out_last only on beat 8; done after the last beat.
- num_lines=0 → done=1 two cycles after start; no c0_req_valid.
- MAX_OUTSTANDING=4, num_lines=16, out_ready=0 → exactly 4 requests issue, then stall. Releasing out_ready completes all 16 in order with no loss.
- c0_alm_full held for 10 cycles mid-RUN → at most 1 request issues after it rises; issue resumes 2 cycles after it falls.
- Response injected in DRAIN with outstanding==0 → err=1, held until the next start clears it; FIFO contents unchanged.
- reset_n low mid-RUN with 3 reads outstanding → all outputs at reset values; late responses ignored with err=0; a new start runs cleanly.
